// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_pkg : shared UART constants and receiver state encoding        |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
package uart_pkg;

  localparam int c_CLKS_PER_BIT_DEFAULT = 87;
  localparam int c_DATA_BITS            = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_CLEANUP = 3'd4
  } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_rx_sync : two-flop synchronizer for the serial line (idle 1)   |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
module uart_rx_sync (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Async,
  output logic o_Sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_Async;
      r_sync <= r_meta;
    end
  end

  assign o_Sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_rx : 8N1 UART receiver, LSB first, mid-bit sampling            |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = c_CLKS_PER_BIT_DEFAULT
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Frame_Err
);

  localparam logic [7:0] c_HALF = 8'((CLKS_PER_BIT - 1) / 2);
  localparam logic [7:0] c_LAST = 8'(CLKS_PER_BIT - 1);

  logic        w_rx_s;
  logic        w_fall;

  uart_state_t r_state;
  logic [7:0]  r_count;
  logic [2:0]  r_bit_index;
  logic [7:0]  r_shift;
  logic [7:0]  r_byte;
  logic        r_dv;
  logic        r_fe;
  logic        r_active;
  logic        r_rx_prev;
  logic [1:0]  r_prime;

  uart_state_t w_state_next;
  logic [7:0]  w_count_next;
  logic [2:0]  w_bit_next;
  logic [7:0]  w_shift_next;
  logic [7:0]  w_byte_next;
  logic        w_dv_next;
  logic        w_fe_next;
  logic        w_active_next;

  uart_rx_sync u_sync (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Async (i_Rx_Serial),
    .o_Sync  (w_rx_s)
  );

  // The previous-sample flop ignores the synchronizer's reset value until the
  // line has propagated through both flops, so a line already low at reset
  // release never looks like a falling edge.
  assign w_fall = r_rx_prev & ~w_rx_s;

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_state     <= S_IDLE;
      r_count     <= 8'd0;
      r_bit_index <= 3'd0;
      r_shift     <= 8'd0;
      r_byte      <= 8'd0;
      r_dv        <= 1'b0;
      r_fe        <= 1'b0;
      r_active    <= 1'b0;
      r_rx_prev   <= 1'b0;
      r_prime     <= 2'b00;
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_bit_index <= w_bit_next;
      r_shift     <= w_shift_next;
      r_byte      <= w_byte_next;
      r_dv        <= w_dv_next;
      r_fe        <= w_fe_next;
      r_active    <= w_active_next;
      r_rx_prev   <= w_rx_s & r_prime[1];
      r_prime     <= {r_prime[0], 1'b1};
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_count_next  = r_count;
    w_bit_next    = r_bit_index;
    w_shift_next  = r_shift;
    w_byte_next   = r_byte;
    w_dv_next     = 1'b0;
    w_fe_next     = 1'b0;
    w_active_next = r_active;

    case (r_state)
      S_IDLE: begin
        w_count_next  = 8'd0;
        w_bit_next    = 3'd0;
        w_active_next = 1'b0;
        if (w_fall) begin
          w_state_next  = S_START;
          w_active_next = 1'b1;
        end
      end

      S_START: begin
        if (r_count == c_HALF) begin
          w_count_next = 8'd0;
          if (!w_rx_s) begin
            w_state_next = S_DATA;
          end else begin
            w_state_next  = S_IDLE;
            w_active_next = 1'b0;
          end
        end else begin
          w_count_next = r_count + 8'd1;
        end
      end

      S_DATA: begin
        if (r_count == c_LAST) begin
          w_count_next              = 8'd0;
          w_shift_next[r_bit_index] = w_rx_s;
          if (r_bit_index == 3'd7) begin
            w_bit_next   = 3'd0;
            w_state_next = S_STOP;
          end else begin
            w_bit_next = r_bit_index + 3'd1;
          end
        end else begin
          w_count_next = r_count + 8'd1;
        end
      end

      S_STOP: begin
        if (r_count == c_LAST) begin
          w_count_next  = 8'd0;
          w_state_next  = S_CLEANUP;
          w_active_next = 1'b0;
          if (w_rx_s) begin
            w_byte_next = r_shift;
            w_dv_next   = 1'b1;
          end else begin
            w_fe_next = 1'b1;
          end
        end else begin
          w_count_next = r_count + 8'd1;
        end
      end

      S_CLEANUP: begin
        w_state_next  = S_IDLE;
        w_active_next = 1'b0;
      end

      default: begin
        w_state_next  = S_IDLE;
        w_count_next  = 8'd0;
        w_bit_next    = 3'd0;
        w_active_next = 1'b0;
      end
    endcase
  end

  assign o_Rx_DV     = r_dv;
  assign o_Rx_Byte   = r_byte;
  assign o_Rx_Active = r_active;
  assign o_Frame_Err = r_fe;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_uart_rx : frame-level reference model bench for uart_rx          |
// | Revision   : 1.0                                                    |
// +--------------------------------------------------------------------+
module tb_uart_rx;

  localparam int C = 87;
  localparam int H = (C - 1) / 2;

  logic       i_Clock     = 1'b0;
  logic       i_Reset     = 1'b0;
  logic       i_Rx_Serial = 1'b1;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Active;
  logic       o_Frame_Err;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_Rx_Serial (i_Rx_Serial),
    .o_Rx_DV     (o_Rx_DV),
    .o_Rx_Byte   (o_Rx_Byte),
    .o_Rx_Active (o_Rx_Active),
    .o_Frame_Err (o_Frame_Err)
  );

  always #5 i_Clock = ~i_Clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge i_Clock) cyc <= cyc + 1;

  // One entry per frame put on the line: what the receiver must report.
  typedef struct {
    bit         is_fe;
    logic [7:0] data;
    int         fall;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e_cur;
  logic [7:0] model_byte = 8'h00;
  int         dv_seen    = 0;
  int         fe_seen    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Strobe must arrive after the stop-bit centre (9.5 bit times after the
  // start edge) plus synchronizer and cleanup latency.
  always @(negedge i_Clock) begin
    if (i_Reset) begin
      if (o_Rx_DV && o_Frame_Err) check("dv_fe_exclusive", 1, 0);
      if (o_Rx_DV || o_Frame_Err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {30'd0, o_Rx_DV, o_Frame_Err}, 0);
        end else begin
          e_cur = exp_q.pop_front();
          check("strobe_kind_fe", {31'd0, o_Frame_Err}, {31'd0, e_cur.is_fe});
          check("strobe_latency_ok",
                {31'd0, (cyc - e_cur.fall >= 9*C + H) && (cyc - e_cur.fall <= 9*C + H + 8)}, 1);
          if (o_Rx_DV) begin
            check("rx_byte", {24'd0, o_Rx_Byte}, {24'd0, e_cur.data});
            model_byte = e_cur.data;
            dv_seen++;
          end else begin
            fe_seen++;
          end
        end
      end
      check("byte_held", {24'd0, o_Rx_Byte}, {24'd0, model_byte});
    end
  end

  task automatic idle(input int n);
    i_Rx_Serial = 1'b1;
    repeat (n) @(negedge i_Clock);
  endtask

  task automatic send_bit(input logic b);
    i_Rx_Serial = b;
    repeat (C) @(negedge i_Clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    exp_q.push_back('{is_fe: !stop, data: d, fall: cyc});
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    i_Rx_Serial = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge i_Clock);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    repeat (95000) @(posedge i_Clock);
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dv0, fe0, kind, glen;
    logic [7:0] rb;

    // Reset state
    repeat (5) @(negedge i_Clock);
    check("reset_dv",     {31'd0, o_Rx_DV}, 0);
    check("reset_fe",     {31'd0, o_Frame_Err}, 0);
    check("reset_active", {31'd0, o_Rx_Active}, 0);
    check("reset_byte",   {24'd0, o_Rx_Byte}, 0);
    i_Reset = 1'b1;
    idle(20);

    // 0xA5 good frame
    dv0 = dv_seen; fe0 = fe_seen;
    send_frame(8'hA5, 1'b1);
    idle(C);
    drain();
    check("a5_byte",     {24'd0, o_Rx_Byte}, 32'hA5);
    check("a5_dv_count", dv_seen - dv0, 1);
    check("a5_fe_count", fe_seen - fe0, 0);

    // 20-cycle glitch
    dv0 = dv_seen; fe0 = fe_seen;
    i_Rx_Serial = 1'b0;
    repeat (10) @(negedge i_Clock);
    check("glitch_active_high", {31'd0, o_Rx_Active}, 1);
    repeat (10) @(negedge i_Clock);
    i_Rx_Serial = 1'b1;
    repeat (H) @(negedge i_Clock);
    check("glitch_active_low", {31'd0, o_Rx_Active}, 0);
    idle(2*C);
    check("glitch_no_strobe", (dv_seen - dv0) + (fe_seen - fe0), 0);

    // 0x3C with stop low
    dv0 = dv_seen; fe0 = fe_seen;
    send_frame(8'h3C, 1'b0);
    idle(2*C);
    drain();
    check("ferr_byte_kept", {24'd0, o_Rx_Byte}, 32'hA5);
    check("ferr_fe_count",  fe_seen - fe0, 1);
    check("ferr_dv_count",  dv_seen - dv0, 0);

    // back-to-back 0x00, 0xFF
    dv0 = dv_seen;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(2*C);
    drain();
    check("b2b_dv_count", dv_seen - dv0, 2);
    check("b2b_last_byte", {24'd0, o_Rx_Byte}, 32'hFF);

    // break: one framing error, no restart while held low
    fe0 = fe_seen; dv0 = dv_seen;
    exp_q.push_back('{is_fe: 1'b1, data: 8'h00, fall: cyc});
    i_Rx_Serial = 1'b0;
    repeat (15*C) @(negedge i_Clock);
    check("break_active_low", {31'd0, o_Rx_Active}, 0);
    idle(2*C);
    drain();
    check("break_fe_count", fe_seen - fe0, 1);
    check("break_dv_count", dv_seen - dv0, 0);

    // reset during data bit 3 of 0x96
    dv0 = dv_seen; fe0 = fe_seen;
    rb = 8'h96;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(rb[i]);
    i_Rx_Serial = rb[3];
    repeat (C/2) @(negedge i_Clock);
    i_Reset = 1'b0;
    @(negedge i_Clock);
    check("midrst_dv",     {31'd0, o_Rx_DV}, 0);
    check("midrst_fe",     {31'd0, o_Frame_Err}, 0);
    check("midrst_active", {31'd0, o_Rx_Active}, 0);
    check("midrst_byte",   {24'd0, o_Rx_Byte}, 0);
    model_byte  = 8'h00;
    i_Rx_Serial = 1'b1;
    repeat (10) @(negedge i_Clock);
    i_Reset = 1'b1;
    idle(20);
    send_frame(8'h5A, 1'b1);
    idle(C);
    drain();
    check("postrst_byte",     {24'd0, o_Rx_Byte}, 32'h5A);
    check("postrst_dv_count", dv_seen - dv0, 1);
    check("postrst_fe_count", fe_seen - fe0, 0);

    // reset released with line already low
    dv0 = dv_seen; fe0 = fe_seen;
    i_Reset     = 1'b0;
    i_Rx_Serial = 1'b0;
    repeat (5) @(negedge i_Clock);
    model_byte = 8'h00;
    i_Reset    = 1'b1;
    repeat (3*C) @(negedge i_Clock);
    check("lowrel_active", {31'd0, o_Rx_Active}, 0);
    idle(20);
    check("lowrel_no_strobe", (dv_seen - dv0) + (fe_seen - fe0), 0);

    // transmitter-style stream 0x01, 0x80, 0x55
    dv0 = dv_seen; fe0 = fe_seen;
    send_frame(8'h01, 1'b1);
    send_frame(8'h80, 1'b1);
    send_frame(8'h55, 1'b1);
    idle(2*C);
    drain();
    check("loop_dv_count", dv_seen - dv0, 3);
    check("loop_fe_count", fe_seen - fe0, 0);
    check("loop_last_byte", {24'd0, o_Rx_Byte}, 32'h55);

    // randomized traffic
    for (int n = 0; n < 35; n++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        glen = $urandom_range(1, H - 8);
        i_Rx_Serial = 1'b0;
        repeat (glen) @(negedge i_Clock);
        idle(H + 10);
      end else begin
        send_frame(8'($urandom_range(0, 255)), kind != 1);
      end
      idle($urandom_range(0, 15));
    end
    idle(2*C);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, i_Clock cycles per serial bit; legal range 4..256.
REQ-002 SHALL have port i_Clock  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port i_Reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_Rx_Serial  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-005 SHALL have port o_Rx_DV  output  1  one-cycle pulse marking a valid received byte.
REQ-006 SHALL have port o_Rx_Byte  output  8  last correctly framed byte; held between pulses.
REQ-007 SHALL have port o_Rx_Active  output  1  high from start-bit detection until return to IDLE.
REQ-008 SHALL have port o_Frame_Err  output  1  one-cycle pulse when the stop bit samples low.

Function
REQ-009 SHALL pass i_Rx_Serial through a 2-flop synchronizer; all decisions use the synchronized value (rx_s).
REQ-010 SHALL implement states IDLE, START, DATA, STOP, CLEANUP; any other encoding returns to IDLE.
REQ-011 IDLE: clock count and bit index held at 0; a cycle with rx_s low after a cycle with rx_s high (falling edge) SHALL move to START and set o_Rx_Active.
REQ-012 A line held low (break) SHALL NOT trigger a new start; a fresh high-to-low edge is required.
REQ-013 START: count 0..(CLKS_PER_BIT-1)/2 (43 at default); at that count, rx_s low -> DATA, count cleared; rx_s high -> glitch, IDLE, o_Rx_Active cleared, no pulse.
REQ-014 DATA: each bit sampled when count reaches CLKS_PER_BIT-1, then count cleared; sample written to shift-register position bit_index (LSB first).
REQ-015 After bit_index 7 is sampled, SHALL go to STOP with bit_index cleared.
REQ-016 STOP: sample rx_s at count CLKS_PER_BIT-1; high -> o_Rx_Byte loaded from shift register and o_Rx_DV pulsed the next cycle; low -> o_Frame_Err pulsed the next cycle, o_Rx_Byte unchanged.
REQ-017 CLEANUP: lasts exactly one cycle; o_Rx_DV/o_Frame_Err high in this cycle only; o_Rx_Active cleared; then IDLE.
REQ-018 Sample points SHALL fall at (CLKS_PER_BIT-1)/2 + k*CLKS_PER_BIT cycles after edge detection, k=1..9 (data k=1..8, stop k=9).
REQ-019 o_Rx_DV and o_Frame_Err SHALL never be high in the same cycle.
REQ-020 Clock counter SHALL be 8 bits and never wrap within a bit period.
REQ-021 A start edge SHALL be accepted the first cycle after CLEANUP, supporting back-to-back frames with one stop bit.

Reset
REQ-022 i_Reset low SHALL immediately force IDLE, count 0, bit_index 0, shift register 0, o_Rx_Byte 0x00, o_Rx_DV 0, o_Rx_Active 0, o_Frame_Err 0, both synchronizer flops 1.
REQ-023 Reset mid-frame SHALL discard the partial byte; no pulse on either strobe.
REQ-024 After reset release, rx_s SHALL require a genuine falling edge before starting (a line already low does not start).

Structure
REQ-025 State encoding constants and the default CLKS_PER_BIT SHALL live in shared package uart_pkg, also used by the transmitter.
REQ-026 The synchronizer SHALL be sub-module uart_rx_sync (2 flops, reset value 1); FSM, counters and shift register stay in uart_rx.

Verification
REQ-027 Byte 0xA5 driven at 87 clk/bit, stop high -> single o_Rx_DV pulse, o_Rx_Byte 0xA5, o_Frame_Err stays 0.
REQ-028 Line low for 20 clocks then high -> no strobe, o_Rx_Active high ~43 cycles then 0, FSM back in IDLE.
REQ-029 Byte 0x3C with stop bit low -> o_Frame_Err one-cycle pulse, no o_Rx_DV, o_Rx_Byte keeps prior value.
REQ-030 Back-to-back 0x00 then 0xFF, no idle gap -> two o_Rx_DV pulses, bytes 0x00 then 0xFF in order.
REQ-031 i_Reset asserted during data bit 3 of 0x96, then 0x5A sent after release -> no strobe for 0x96, outputs 0 during reset, o_Rx_Byte 0x5A afterwards.
REQ-032 Loopback from the transmitter at CLKS_PER_BIT=87, bytes 0x01, 0x80, 0x55 -> each received exactly once, in order, no framing errors.
